// File: rtl/scene_sequencer.sv
// Scene rotation controller: fades each scene in, holds it, fades it out and advances.
// Define SEQ_FADE_EN to enable the fade ramps; otherwise fade is pinned at full brightness.
module scene_sequencer #(
  parameter int NUM_SCENES  = 4,
  parameter int HOLD_FRAMES = 600,
  parameter int FADE_STEP   = 1
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        pause_n,
  input  logic        skip,
  output logic [2:0]  scene,
  output logic [5:0]  fade,
  output logic [10:0] scene_frame,
  output logic        scene_start,
  output logic [1:0]  phase
);

  if (NUM_SCENES < 2 || NUM_SCENES > 8 || HOLD_FRAMES < 1 || HOLD_FRAMES > 2047 ||
      FADE_STEP < 1 || FADE_STEP > 63) begin : g_bad_params
    $error("scene_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2
  } phase_t;

  localparam logic [10:0] HOLD_LAST  = 11'(HOLD_FRAMES - 1);
  localparam logic [2:0]  LAST_SCENE = 3'(NUM_SCENES - 1);

`ifdef SEQ_FADE_EN
  localparam phase_t      RESET_STATE = FADE_IN;
  localparam logic [6:0]  STEP        = 7'(FADE_STEP);
  logic [5:0] fade_nxt;
  logic [6:0] fade_up;
`else
  localparam phase_t      RESET_STATE = HOLD;
`endif

  phase_t      state, state_nxt;
  logic [10:0] hold_cnt, hold_cnt_nxt;
  logic [2:0]  scene_nxt;
  logic [10:0] frame_nxt;
  logic        start_nxt;
  logic        pending, pending_nxt;
  logic        tick, skip_eff, advance;

  assign tick     = frame_tick & pause_n;
  // A skip arriving on the tick itself counts just like an earlier one.
  assign skip_eff = pending | skip;
  assign phase    = state;

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      hold_cnt    <= '0;
      scene       <= '0;
      scene_frame <= '0;
      scene_start <= 1'b0;
      pending     <= 1'b0;
`ifdef SEQ_FADE_EN
      fade        <= '0;
`endif
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      scene       <= scene_nxt;
      scene_frame <= frame_nxt;
      scene_start <= start_nxt;
      pending     <= pending_nxt;
`ifdef SEQ_FADE_EN
      fade        <= fade_nxt;
`endif
    end
  end

`ifndef SEQ_FADE_EN
  assign fade = 6'd63;
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    scene_nxt    = scene;
    frame_nxt    = scene_frame;
    start_nxt    = 1'b0;
    pending_nxt  = skip_eff;
    advance      = 1'b0;
`ifdef SEQ_FADE_EN
    fade_nxt     = fade;
    fade_up      = {1'b0, fade} + STEP;
`endif
    if (tick) begin
      pending_nxt = 1'b0;
`ifdef SEQ_FADE_EN
      case (state)
        FADE_IN: begin
          if (skip_eff) begin
            state_nxt = FADE_OUT;
          end else if (fade_up >= 7'd63) begin
            fade_nxt     = 6'd63;
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
          end else begin
            fade_nxt = fade_up[5:0];
          end
        end
        HOLD: begin
          if (skip_eff || hold_cnt == HOLD_LAST) state_nxt = FADE_OUT;
          else hold_cnt_nxt = hold_cnt + 11'd1;
        end
        FADE_OUT: begin
          // Pending skips are discarded here; the fade-out simply continues.
          if ({1'b0, fade} <= STEP) begin
            fade_nxt  = '0;
            advance   = 1'b1;
            state_nxt = FADE_IN;
          end else begin
            fade_nxt = fade - STEP[5:0];
          end
        end
        default: state_nxt = FADE_IN;
      endcase
`else
      if (skip_eff || hold_cnt == HOLD_LAST) begin
        advance      = 1'b1;
        hold_cnt_nxt = '0;
      end else begin
        hold_cnt_nxt = hold_cnt + 11'd1;
      end
`endif
      if (advance) begin
        scene_nxt = (scene == LAST_SCENE) ? 3'd0 : scene + 3'd1;
        frame_nxt = '0;
        start_nxt = 1'b1;
      end else if (scene_frame != 11'd2047) begin
        frame_nxt = scene_frame + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Self-checking bench for scene_sequencer: per-cycle model comparison plus directed literal checks.
// Covers both builds, selected by SEQ_FADE_EN.
module tb_scene_sequencer;

  localparam int NS   = 4;
  localparam int HF   = 4;
  localparam int STEP = 16;
`ifdef SEQ_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pause_n = 1'b1;
  logic        skip = 1'b0;
  logic [2:0]  scene;
  logic [5:0]  fade;
  logic [10:0] scene_frame;
  logic        scene_start;
  logic [1:0]  phase;

  int checks = 0;
  int failures = 0;

  // Reference model state: phase as 0 fade-in, 1 hold, 2 fade-out.
  int m_scene, m_fade, m_frame, m_start, m_phase, m_hold, m_pending;
  bit chk_en = 1'b0;

  scene_sequencer #(.NUM_SCENES(NS), .HOLD_FRAMES(HF), .FADE_STEP(STEP)) dut (
    .clk48(clk48), .rst_n(rst_n), .frame_tick(frame_tick), .pause_n(pause_n), .skip(skip),
    .scene(scene), .fade(fade), .scene_frame(scene_frame), .scene_start(scene_start), .phase(phase)
  );

  always #5 clk48 = ~clk48;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk48) begin
    if (!rst_n) begin
      m_scene = 0; m_frame = 0; m_start = 0; m_hold = 0; m_pending = 0;
      m_fade  = FADE_EN ? 0 : 63;
      m_phase = FADE_EN ? 0 : 1;
    end else begin
      m_start = 0;
      if (frame_tick && pause_n) begin
        bit sk, adv;
        sk = (m_pending != 0) || skip;
        adv = 1'b0;
        m_pending = 0;
        if (FADE_EN) begin
          if (m_phase == 0) begin
            if (sk) m_phase = 2;
            else begin
              m_fade = (m_fade + STEP > 63) ? 63 : m_fade + STEP;
              if (m_fade == 63) begin m_phase = 1; m_hold = 0; end
            end
          end else if (m_phase == 1) begin
            if (sk || m_hold == HF - 1) m_phase = 2;
            else m_hold++;
          end else begin
            m_fade = (m_fade < STEP) ? 0 : m_fade - STEP;
            if (m_fade == 0) begin adv = 1'b1; m_phase = 0; end
          end
        end else begin
          if (sk || m_hold == HF - 1) begin adv = 1'b1; m_hold = 0; end
          else m_hold++;
        end
        if (adv) begin
          m_scene = (m_scene + 1) % NS;
          m_frame = 0;
          m_start = 1;
        end else begin
          m_frame = (m_frame >= 2047) ? 2047 : m_frame + 1;
        end
      end else if (skip) begin
        m_pending = 1;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk48) begin
    if (chk_en) begin
      check("mdl_scene", int'(scene), m_scene);
      check("mdl_fade", int'(fade), m_fade);
      check("mdl_frame", int'(scene_frame), m_frame);
      check("mdl_start", int'(scene_start), m_start);
      check("mdl_phase", int'(phase), m_phase);
    end
  end

  task automatic do_tick();
    frame_tick = 1'b1;
    @(negedge clk48);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_skip();
    skip = 1'b1;
    @(negedge clk48);
    skip = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk48);
    rst_n = 1'b1;
    check("rst_scene", int'(scene), 0);
    check("rst_frame", int'(scene_frame), 0);
    check("rst_start", int'(scene_start), 0);
`ifdef SEQ_FADE_EN
    check("rst_fade", int'(fade), 0);
    check("rst_phase", int'(phase), 0);
    do_tick(); check("fi_t1", int'(fade), 16);
    do_tick(); check("fi_t2", int'(fade), 32);
    do_tick(); check("fi_t3", int'(fade), 48);
    do_tick(); check("fi_t4", int'(fade), 63);
    check("hold_phase", int'(phase), 1);
    check("frame_t4", int'(scene_frame), 4);
    ticks(3); check("hold_t7", int'(phase), 1);
    do_tick(); check("fo_phase", int'(phase), 2);
    check("fo_t8_fade", int'(fade), 63);
    do_tick(); check("fo_t9", int'(fade), 47);
    do_tick(); check("fo_t10", int'(fade), 31);
    do_tick(); check("fo_t11", int'(fade), 15);
    do_tick(); check("fo_t12", int'(fade), 0);
    check("t12_scene", int'(scene), 1);
    check("t12_start", int'(scene_start), 1);
    check("t12_phase", int'(phase), 0);
    @(negedge clk48); check("start_drop", int'(scene_start), 0);
    ticks(12); check("t24_scene", int'(scene), 2);
    ticks(12); check("t36_scene", int'(scene), 3);
    ticks(11); check("t47_scene", int'(scene), 3);
    do_tick(); check("wrap_scene", int'(scene), 0);
    check("wrap_start", int'(scene_start), 1);
    ticks(4); check("sk_pre_fade", int'(fade), 63);
    pulse_skip();
    do_tick(); check("sk_phase", int'(phase), 2);
    check("sk_fade", int'(fade), 63);
    do_tick(); check("sk_next", int'(fade), 47);
    pulse_skip();
    do_tick(); check("sk_fo_fade", int'(fade), 31);
    check("sk_fo_phase", int'(phase), 2);
    ticks(2); check("sk_adv_scene", int'(scene), 1);
    do_tick(); check("sk_clear_fade", int'(fade), 16);
    check("sk_clear_phase", int'(phase), 0);
    pause_n = 1'b0;
    ticks(10);
    check("pz_scene", int'(scene), 1);
    check("pz_fade", int'(fade), 16);
    check("pz_frame", int'(scene_frame), 1);
    check("pz_phase", int'(phase), 0);
    pulse_skip();
    pause_n = 1'b1;
    do_tick(); check("pzsk_phase", int'(phase), 2);
    check("pzsk_fade", int'(fade), 16);
    do_tick(); check("pzsk_scene", int'(scene), 2);
    check("pzsk_start", int'(scene_start), 1);
    ticks(9); check("rstfo_pre", int'(fade), 47);
    rst_n = 1'b0;
    @(negedge clk48);
    check("rstfo_fade", int'(fade), 0);
    check("rstfo_scene", int'(scene), 0);
    check("rstfo_phase", int'(phase), 0);
    rst_n = 1'b1;
`else
    check("rst_fade", int'(fade), 63);
    check("rst_phase", int'(phase), 1);
    ticks(3); check("nf_t3_frame", int'(scene_frame), 3);
    check("nf_t3_scene", int'(scene), 0);
    do_tick(); check("nf_t4_scene", int'(scene), 1);
    check("nf_t4_start", int'(scene_start), 1);
    check("nf_t4_frame", int'(scene_frame), 0);
    @(negedge clk48); check("nf_start_drop", int'(scene_start), 0);
    ticks(12); check("nf_wrap", int'(scene), 0);
    check("nf_fade", int'(fade), 63);
    pulse_skip();
    do_tick(); check("nf_skip", int'(scene), 1);
    skip = 1'b1;
    do_tick();
    skip = 1'b0;
    check("nf_skip_same", int'(scene), 2);
    do_tick(); check("nf_after_skip", int'(scene_frame), 1);
    pause_n = 1'b0;
    ticks(10);
    check("nf_pz_scene", int'(scene), 2);
    check("nf_pz_frame", int'(scene_frame), 1);
    pulse_skip();
    pause_n = 1'b1;
    do_tick(); check("nf_pzsk", int'(scene), 3);
    ticks(2);
    rst_n = 1'b0;
    @(negedge clk48);
    check("nf_rst_scene", int'(scene), 0);
    check("nf_rst_fade", int'(fade), 63);
    check("nf_rst_phase", int'(phase), 1);
    rst_n = 1'b1;
`endif
    ticks(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scene_sequencer.md
SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 SHALL have parameter NUM_SCENES, default 4, number of scenes in the rotation (legal range 2..8).
REQ-002 SHALL have parameter HOLD_FRAMES, default 600, frames spent at full brightness per scene (legal range 1..2047).
REQ-003 SHALL have parameter FADE_STEP, default 1, brightness change per frame during a fade (legal range 1..63).
REQ-004 SHALL have port clk48  input  1  system clock (48 MHz).
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse, one per video frame (start of vblank).
REQ-007 SHALL have port pause_n  input  1  low freezes all sequencing; frame_tick is ignored while low.
REQ-008 SHALL have port skip  input  1  one-cycle request to leave the current scene early.
REQ-009 SHALL have port scene  output  3  current scene index for the effect datapath.
REQ-010 SHALL have port fade  output  6  brightness level (0 = black, 63 = full), applied before dithering.
REQ-011 SHALL have port scene_frame  output  11  frames elapsed in the current scene.
REQ-012 SHALL have port scene_start  output  1  one-cycle pulse on each scene change.
REQ-013 SHALL have port phase  output  2  current state: 0 FADE_IN, 1 HOLD, 2 FADE_OUT.

Function
REQ-014 SHALL define an active tick as a clk48 cycle with frame_tick=1 and pause_n=1 and rst_n=1.
REQ-015 SHALL change state and outputs only on active ticks; scene_start is the only exception and SHALL return to 0 on the next cycle.
REQ-016 SHALL register all outputs, so each update is visible on the cycle after the active tick.
REQ-017 FADE_IN: fade <= min(fade+FADE_STEP, 63); when the new value is 63, go to HOLD with the hold counter set to 0.
REQ-018 HOLD: hold counter increments; on the tick where the counter equals HOLD_FRAMES-1, go to FADE_OUT.
REQ-019 FADE_OUT: fade <= max(fade-FADE_STEP, 0); when the new value is 0, on that same tick:
  - scene <= (scene+1) mod NUM_SCENES
  - scene_frame <= 0
  - scene_start pulses
  - state goes to FADE_IN
REQ-020 Outside a scene change, scene_frame SHALL increment by 1 on every active tick and saturate at 2047.
REQ-021 A skip pulse SHALL set a sticky skip_pending flag regardless of pause_n.
REQ-022 On an active tick in FADE_IN or HOLD with skip_pending set (including skip asserted in the same cycle):
  - enter FADE_OUT from the current fade level
  - do not apply a fade increment on that tick
  - clear skip_pending
REQ-023 skip_pending SHALL be cleared without effect when an active tick occurs in FADE_OUT.
REQ-024 The scene wrap from NUM_SCENES-1 to 0 SHALL be seamless, with no extra frames.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set:
  - scene=0, fade=0, scene_frame=0, scene_start=0
  - phase=FADE_IN, hold counter=0, skip_pending=0
REQ-026 Reset SHALL take priority over frame_tick and skip, and SHALL abort any fade in progress.

Configuration
REQ-027 Macro SEQ_FADE_EN: when defined, FADE_IN and FADE_OUT SHALL behave per REQ-017..REQ-019.
REQ-028 When SEQ_FADE_EN is not defined:
  - fade SHALL be constant 63, including during reset
  - phase SHALL stay at HOLD (the reset value of phase is HOLD)
  - on the expiry tick of REQ-018, or on a skip per REQ-022, the scene advances per REQ-019 and the hold counter clears on that tick.

Verification (NUM_SCENES=4, HOLD_FRAMES=4, FADE_STEP=16, SEQ_FADE_EN defined unless stated)
REQ-029 Reset then 4 active ticks -> fade 16,32,48,63; phase=HOLD after the 4th tick; scene_frame=4.
REQ-030 Continue 4 ticks then 4 more -> phase=FADE_OUT after tick 8; fade 47,31,15,0; at tick 12 scene=1, scene_start high for exactly 1 cycle, phase=FADE_IN.
REQ-031 Run 48 active ticks from reset -> scene sequence 0,1,2,3,0, each scene change 12 ticks apart.
REQ-032 Pulse skip during HOLD (fade=63), then 1 tick -> phase=FADE_OUT, fade=63; next ticks give 47,…; skip during FADE_OUT produces no change.
REQ-033 Hold pause_n=0 across 10 frame_ticks -> all outputs unchanged; rst_n=0 mid FADE_OUT -> fade=0, scene=0 next cycle.
REQ-034 SEQ_FADE_EN undefined: fade=63 always; scene advances every 4 ticks; skip advances the scene on the next active tick.
